// File: rtl/execute_muldiv.sv
// MIPS execute stage: ID/EX capture register, single-cycle ALU and an iterative
// 32-step multiply/divide engine with HI/LO registers that stalls upstream while busy.
module execute_muldiv #(
    parameter int unsigned MULDIV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] register_rs,
    input  logic [31:0] register_rt,
    input  logic [31:0] sign_extend,
    input  logic [4:0]  wreg_rd,
    input  logic [4:0]  wreg_rt,
    input  logic [1:0]  aluop,
    input  logic        alusrc,
    input  logic        regdst,
    input  logic        regwrite_in,
    input  logic        memtoreg_in,
    input  logic        memwrite_in,
    output logic        busy,
    output logic        valid_out,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [31:0] store_data,
    output logic [4:0]  wreg_address,
    output logic        regwrite,
    output logic        memtoreg,
    output logic        memwrite
);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_next;

    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] op_a, op_b, result;
    logic        wb_en, is_muldiv, start;

    logic [5:0]  count;
    logic [63:0] prod, prod_step, prod_fin;
    logic [31:0] mcand, hi, lo;
    logic        op_div, neg_lo, neg_hi;
    logic        sgn;
    logic [31:0] mag_a, mag_b;
    logic [32:0] shifted, diff, sum;

    assign funct = sign_extend[5:0];
    assign shamt = sign_extend[10:6];
    assign busy  = (state == RUN);
    assign start = (state == IDLE) && valid_in && is_muldiv;

    always_comb begin
        result    = '0;
        wb_en     = 1'b1;
        is_muldiv = 1'b0;
        op_a      = register_rs;
        op_b      = alusrc ? sign_extend : register_rt;
        case (aluop)
            2'b01: result = op_a - op_b;
            2'b10: begin
                case (funct)
                    6'h20, 6'h21: result = op_a + op_b;
                    6'h22, 6'h23: result = op_a - op_b;
                    6'h24: result = op_a & op_b;
                    6'h25: result = op_a | op_b;
                    6'h26: result = op_a ^ op_b;
                    6'h27: result = ~(op_a | op_b);
                    6'h2A: result = {31'b0, $signed(op_a) < $signed(op_b)};
                    6'h2B: result = {31'b0, op_a < op_b};
                    6'h00: result = register_rt << shamt;
                    6'h02: result = register_rt >> shamt;
                    6'h03: result = 32'($signed(register_rt) >>> shamt);
                    6'h10: result = hi;
                    6'h12: result = lo;
                    6'h18, 6'h19, 6'h1A, 6'h1B: begin
                        is_muldiv = 1'b1;
                        wb_en     = 1'b0;
                    end
                    default: wb_en = 1'b0;
                endcase
            end
            default: result = op_a + op_b;
        endcase
    end

    // Engine works on magnitudes; signs are reapplied when HI/LO are written.
    always_comb begin
        sgn   = ~funct[0];
        mag_a = (sgn && register_rs[31]) ? -register_rs : register_rs;
        mag_b = (sgn && register_rt[31]) ? -register_rt : register_rt;
    end

    always_comb begin
        shifted   = {prod[63:32], prod[31]};
        diff      = shifted - {1'b0, mcand};
        sum       = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
        prod_step = prod;
        if (op_div) begin
            if (!diff[32]) prod_step = {diff[31:0], prod[30:0], 1'b1};
            else           prod_step = {shifted[31:0], prod[30:0], 1'b0};
        end else begin
            prod_step = {sum, prod[31:1]};
        end
        if (op_div) begin
            prod_fin[31:0]  = neg_lo ? -prod_step[31:0]  : prod_step[31:0];
            prod_fin[63:32] = neg_hi ? -prod_step[63:32] : prod_step[63:32];
        end else begin
            prod_fin = neg_lo ? -prod_step : prod_step;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (count == 6'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            prod   <= '0;
            mcand  <= '0;
            op_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (start) begin
            count  <= MULDIV_CYCLES[5:0];
            op_div <= funct[1];
            // Divide by zero runs unsigned on the raw dividend: quotient all ones, remainder = dividend.
            if (funct[1] && register_rt == '0) begin
                prod   <= {32'b0, register_rs};
                mcand  <= '0;
                neg_lo <= 1'b0;
                neg_hi <= 1'b0;
            end else if (funct[1]) begin
                prod   <= {32'b0, mag_a};
                mcand  <= mag_b;
                neg_lo <= sgn && (register_rs[31] ^ register_rt[31]);
                neg_hi <= sgn && register_rs[31];
            end else begin
                prod   <= {32'b0, mag_b};
                mcand  <= mag_a;
                neg_lo <= sgn && (register_rs[31] ^ register_rt[31]);
                neg_hi <= 1'b0;
            end
        end else if (state == RUN) begin
            prod  <= prod_step;
            count <= count - 6'd1;
            if (count == 6'd1) begin
                hi <= prod_fin[63:32];
                lo <= prod_fin[31:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_out    <= 1'b0;
            alu_result   <= '0;
            zero         <= 1'b0;
            store_data   <= '0;
            wreg_address <= '0;
            regwrite     <= 1'b0;
            memtoreg     <= 1'b0;
            memwrite     <= 1'b0;
        end else if (busy || !valid_in) begin
            valid_out <= 1'b0;
            regwrite  <= 1'b0;
            memwrite  <= 1'b0;
        end else begin
            valid_out    <= 1'b1;
            alu_result   <= result;
            zero         <= (result == '0);
            store_data   <= register_rt;
            wreg_address <= regdst ? wreg_rd : wreg_rt;
            regwrite     <= regwrite_in && wb_en;
            memtoreg     <= memtoreg_in;
            memwrite     <= memwrite_in;
        end
    end

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed self-checking bench for execute_muldiv: ALU ops, mult/div engine,
// stall behaviour and reset during an engine operation.
module tb_execute_muldiv;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] register_rs, register_rt, sign_extend;
    logic [4:0]  wreg_rd, wreg_rt;
    logic [1:0]  aluop;
    logic        alusrc, regdst, regwrite_in, memtoreg_in, memwrite_in;
    logic        busy, valid_out, zero, regwrite, memtoreg, memwrite;
    logic [31:0] alu_result, store_data;
    logic [4:0]  wreg_address;

    int tests = 0;
    int failures = 0;

    execute_muldiv #(.MULDIV_CYCLES(32)) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in),
        .register_rs(register_rs), .register_rt(register_rt), .sign_extend(sign_extend),
        .wreg_rd(wreg_rd), .wreg_rt(wreg_rt), .aluop(aluop), .alusrc(alusrc),
        .regdst(regdst), .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
        .memwrite_in(memwrite_in), .busy(busy), .valid_out(valid_out),
        .alu_result(alu_result), .zero(zero), .store_data(store_data),
        .wreg_address(wreg_address), .regwrite(regwrite), .memtoreg(memtoreg),
        .memwrite(memwrite)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_r(input logic [5:0] funct, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] shamt, input logic [4:0] rd);
        valid_in    = 1'b1;
        aluop       = 2'b10;
        alusrc      = 1'b0;
        regdst      = 1'b1;
        regwrite_in = 1'b1;
        memtoreg_in = 1'b0;
        memwrite_in = 1'b0;
        register_rs = rs;
        register_rt = rt;
        sign_extend = {21'b0, shamt, funct};
        wreg_rd     = rd;
        wreg_rt     = 5'd9;
    endtask

    // Counts busy cycles after a start edge and confirms every stalled edge is a bubble.
    task automatic wait_idle(input string tag);
        int n = 0;
        logic bub = 1'b1;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
            if (valid_out !== 1'b0 || regwrite !== 1'b0 || memwrite !== 1'b0) bub = 1'b0;
        end
        check({tag, " busy cycles"}, 32'(n), 32'd32);
        check({tag, " stall bubble"}, {31'b0, bub}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        set_r(6'h20, 32'd0, 32'd0, 5'd0, 5'd0);
        valid_in = 1'b0;
        tick();
        check("reset valid_out", {31'b0, valid_out}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset alu_result", alu_result, 32'd0);
        check("reset zero", {31'b0, zero}, 32'd0);
        check("reset regwrite", {31'b0, regwrite}, 32'd0);
        check("reset wreg_address", {27'b0, wreg_address}, 32'd0);
        reset = 1'b0;

        set_r(6'h20, 32'd7, 32'd5, 5'd0, 5'd3);
        tick();
        check("add result", alu_result, 32'h0000000C);
        check("add wreg", {27'b0, wreg_address}, 32'd3);
        check("add regwrite", {31'b0, regwrite}, 32'd1);
        check("add valid", {31'b0, valid_out}, 32'd1);
        check("add zero", {31'b0, zero}, 32'd0);

        set_r(6'h2A, 32'hFFFFFFFF, 32'd1, 5'd0, 5'd4);
        tick();
        check("slt result", alu_result, 32'd1);
        set_r(6'h2B, 32'hFFFFFFFF, 32'd1, 5'd0, 5'd4);
        tick();
        check("sltu result", alu_result, 32'd0);
        check("sltu zero", {31'b0, zero}, 32'd1);
        set_r(6'h03, 32'd0, 32'h80000000, 5'd4, 5'd4);
        tick();
        check("sra result", alu_result, 32'hF8000000);

        set_r(6'h00, 32'd16, 32'h1234, 5'd0, 5'd4);
        aluop = 2'b00; alusrc = 1'b1; regdst = 1'b0; sign_extend = 32'hFFFFFFFC; memwrite_in = 1'b1;
        tick();
        check("addi result", alu_result, 32'h0000000C);
        check("addi wreg rt", {27'b0, wreg_address}, 32'd9);
        check("addi memwrite", {31'b0, memwrite}, 32'd1);
        check("addi store_data", store_data, 32'h1234);

        set_r(6'h3F, 32'd7, 32'd5, 5'd0, 5'd4);
        tick();
        check("bad funct result", alu_result, 32'd0);
        check("bad funct regwrite", {31'b0, regwrite}, 32'd0);

        set_r(6'h18, 32'hFFFFFFFD, 32'd5, 5'd0, 5'd0);
        tick();
        check("mult valid", {31'b0, valid_out}, 32'd1);
        check("mult regwrite", {31'b0, regwrite}, 32'd0);
        check("mult result", alu_result, 32'd0);
        check("mult busy", {31'b0, busy}, 32'd1);
        set_r(6'h20, 32'h100, 32'd5, 5'd0, 5'd6);
        wait_idle("mult");
        check("held add not yet taken", {31'b0, valid_out}, 32'd0);
        tick();
        check("held add result", alu_result, 32'h00000105);
        check("held add valid", {31'b0, valid_out}, 32'd1);
        set_r(6'h10, 32'd0, 32'd0, 5'd0, 5'd1);
        tick();
        check("mult mfhi", alu_result, 32'hFFFFFFFF);
        set_r(6'h12, 32'd0, 32'd0, 5'd0, 5'd1);
        tick();
        check("mult mflo", alu_result, 32'hFFFFFFF1);

        set_r(6'h1A, 32'd7, 32'hFFFFFFFE, 5'd0, 5'd0);
        tick();
        set_r(6'h12, 32'd0, 32'd0, 5'd0, 5'd1);
        wait_idle("div");
        tick();
        check("div mflo", alu_result, 32'hFFFFFFFD);
        set_r(6'h10, 32'd0, 32'd0, 5'd0, 5'd1);
        tick();
        check("div mfhi", alu_result, 32'd1);

        set_r(6'h1A, 32'h80000000, 32'hFFFFFFFF, 5'd0, 5'd0);
        tick();
        set_r(6'h12, 32'd0, 32'd0, 5'd0, 5'd1);
        wait_idle("div ovf");
        tick();
        check("div ovf mflo", alu_result, 32'h80000000);
        set_r(6'h10, 32'd0, 32'd0, 5'd0, 5'd1);
        tick();
        check("div ovf mfhi", alu_result, 32'd0);

        set_r(6'h1B, 32'd9, 32'd0, 5'd0, 5'd0);
        tick();
        set_r(6'h12, 32'd0, 32'd0, 5'd0, 5'd1);
        wait_idle("divu0");
        tick();
        check("divu0 mflo", alu_result, 32'hFFFFFFFF);
        set_r(6'h10, 32'd0, 32'd0, 5'd0, 5'd1);
        tick();
        check("divu0 mfhi", alu_result, 32'd9);

        set_r(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 5'd0);
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        check("mid reset busy", {31'b0, busy}, 32'd0);
        check("mid reset valid", {31'b0, valid_out}, 32'd0);
        check("mid reset alu_result", alu_result, 32'd0);
        check("mid reset regwrite", {31'b0, regwrite}, 32'd0);
        reset = 1'b0;
        set_r(6'h10, 32'd0, 32'd0, 5'd0, 5'd1);
        tick();
        check("post reset mfhi", alu_result, 32'd0);
        check("post reset busy", {31'b0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
- MIPS execute stage that consumes the decode stage outputs (register_rs, register_rt, sign_extend, wreg_rd, wreg_rt) plus control signals.
- Produces the ALU result, the write-register address and the writeback controls that are returned to decode (alu_result, wreg_address, regwrite, memtoreg).
- Contains an ID/EX capture register, a single-cycle ALU, and an iterative 32-cycle multiply/divide engine with HI/LO registers.
- Stalls upstream while the engine is busy.

Parameters:
- MULDIV_CYCLES, 32, number of busy cycles for a mult/multu/div/divu operation. Fixed at 32; other values are unsupported.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  decode presents a real instruction (0 = bubble).
- register_rs  in  32  rs operand.
- register_rt  in  32  rt operand; also store data.
- sign_extend  in  32  sign-extended immediate; [10:6] = shamt, [5:0] = funct.
- wreg_rd  in  5  rd field.
- wreg_rt  in  5  rt field.
- aluop  in  2  00 add, 01 sub, 10 R-type (decode funct), 11 reserved (treated as add).
- alusrc  in  1  1 = operand B is sign_extend, 0 = operand B is register_rt.
- regdst  in  1  1 = destination is wreg_rd, 0 = destination is wreg_rt.
- regwrite_in  in  1  instruction writes the register file.
- memtoreg_in  in  1  result comes from memory.
- memwrite_in  in  1  store.
- busy  out  1  mult/div in progress; upstream holds its inputs.
- valid_out  out  1  outputs hold a real instruction.
- alu_result  out  32  ALU or HI/LO result.
- zero  out  1  alu_result == 0.
- store_data  out  32  registered register_rt.
- wreg_address  out  5  selected destination register.
- regwrite  out  1  registered regwrite_in, gated as described below.
- memtoreg  out  1  registered memtoreg_in.
- memwrite  out  1  registered memwrite_in.

Behaviour:
- Reset: every output, HI, LO, the engine counter and the engine operands are 0; busy = 0.
- A reset asserted mid-operation aborts the engine immediately. HI/LO are left at 0.
- Accept rule: the inputs are sampled at a rising edge when busy = 0. While busy = 1 the inputs are ignored and must be held by upstream.
- Latency: 1 cycle. The outputs are registered and reflect the instruction accepted on the previous edge.
- While busy = 1, or when valid_in = 0, the edge loads a bubble: valid_out = 0, regwrite = 0, memwrite = 0.
- Operand A = register_rs. Operand B = sign_extend when alusrc = 1, else register_rt.
- wreg_address = wreg_rd when regdst = 1, else wreg_rt.
- R-type funct decode (hex):
  - 20/21 add; 22/23 sub; 24 and; 25 or; 26 xor; 27 nor.
  - 2A slt (signed, result 0 or 1); 2B sltu (unsigned, result 0 or 1).
  - 00 sll rt by shamt; 02 srl rt by shamt; 03 sra rt by shamt.
  - 10 mfhi; 12 mflo.
  - 18 mult; 19 multu; 1A div; 1B divu.
  - Any other funct: result 0 and regwrite forced to 0.
- All arithmetic is 32-bit and wraps; overflow never traps.
- Mult/div start: on accepting a valid mult/multu/div/divu, that edge latches the operands, sets the counter to 32 and sets busy = 1. The instruction itself is emitted with valid_out = 1, regwrite = 0 and alu_result = 0.
- Engine: one shift-add (multiply) or restoring-subtract (divide) step per cycle on magnitudes.
- The edge at which the counter goes 1 -> 0 writes HI/LO and clears busy, i.e. busy is high for exactly 32 cycles. The next instruction is accepted at the following edge.
- mult/multu: {HI, LO} = 64-bit product, signed or unsigned.
- div/divu: LO = quotient, HI = remainder.
  - Signed divide truncates toward zero; the quotient is negated when the operand signs differ; the remainder takes the sign of the dividend.
- Divide by zero, signed and unsigned: LO = FFFFFFFF, HI = dividend. No trap; the engine still runs 32 cycles.
- Signed 80000000 / FFFFFFFF: LO = 80000000, HI = 0.
- mfhi/mflo accepted after a mult/div always read the final HI/LO, because the engine has completed before acceptance is possible.
- zero is computed from the final alu_result value.

Test Plan:
- Add: aluop=10, funct 20, rs=7, rt=5, regdst=1, rd=3 -> next cycle alu_result=0000000C, wreg_address=3, regwrite=1, valid_out=1.
- Signed compare and shift:
  - slt with rs=FFFFFFFF, rt=1 -> alu_result=1.
  - sltu with the same operands -> 0.
  - sra with rt=80000000, shamt=4 -> F8000000.
- Signed multiply: mult rs=FFFFFFFD, rt=5 -> busy high exactly 32 cycles; then mfhi -> FFFFFFFF and mflo -> FFFFFFF1.
- Signed divide: div 7 / FFFFFFFE -> mflo=FFFFFFFD, mfhi=1. Also divu 9 / 0 -> LO=FFFFFFFF, HI=9.
- Stall: while busy=1, change register_rs and valid_in -> the outputs stay as a bubble and the new inputs are not captured until busy=0.
- Reset mid-operation: reset asserted 10 cycles into a multu -> the next cycle has busy=0 and all outputs 0; a following mfhi returns 0.
